// File: rtl/button_event_queue.sv
`default_nettype none
// button_event_queue: timestamps masked button press pulses into a FWFT queue
// with sticky overflow, saturating drop counter and per-entry lost marker.
module button_event_queue #(
  parameter int N_BUTTONS = 4,
  parameter int DEPTH     = 8,
  parameter int TS_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BUTTONS-1:0]       pressed,
  input  logic [N_BUTTONS-1:0]       btn_en,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [31:0]                dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_WIDTH-1:0]  ts_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drop_q, drop_d;
  logic [31:0]          mem_q [DEPTH];

  logic [N_BUTTONS-1:0] ev;
  logic                 has_ev, empty_w, full_w;
  logic                 do_rd, do_wr, do_drop;
  logic [31:0]          entry;

  always_comb begin
    ev      = pressed & btn_en;
    has_ev  = |ev;
    empty_w = (count_q == '0);
    full_w  = (count_q == (AW+1)'(DEPTH));
    do_rd   = rd_en & ~empty_w;
    // When full, a same-cycle pop always succeeds, so it frees the slot.
    do_wr   = has_ev & (~full_w | rd_en);
    do_drop = has_ev & full_w & ~rd_en;

    entry                  = '0;
    entry[N_BUTTONS-1:0]   = ev;
    entry[N_BUTTONS]       = pend_q;
    entry[31 -: TS_WIDTH]  = ts_q;

    count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);

    pend_d = pend_q;
    if (do_drop)    pend_d = 1'b1;
    else if (do_wr) pend_d = 1'b0;

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (do_drop) begin
      // A drop coinciding with a clear restarts the count at one.
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      count_q <= count_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is not reset; an empty count hides stale contents from dout.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= entry;
  end

  assign dout       = empty_w ? 32'd0 : mem_q[rd_ptr_q];
  assign empty      = empty_w;
  assign full       = full_w;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// tb_button_event_queue: directed + random stimulus against a queue-based model;
// a TS_WIDTH=4 twin shares the stimulus to exercise timestamp wrap.
module tb_button_event_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pressed, btn_en;
  logic        rd_en, clr_ovf;
  logic [31:0] dout, dout4;
  logic        empty, full, overflow, empty4, full4, overflow4;
  logic [3:0]  count, count4;
  logic [7:0]  drop_count, drop_count4;

  always #5 clk = ~clk;

  button_event_queue #(.N_BUTTONS(4), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .pressed(pressed), .btn_en(btn_en),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .dout(dout), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  button_event_queue #(.N_BUTTONS(4), .DEPTH(8), .TS_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pressed(pressed), .btn_en(btn_en),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .dout(dout4), .empty(empty4),
    .full(full4), .count(count4), .overflow(overflow4), .drop_count(drop_count4)
  );

  typedef struct {
    int       ts;
    bit       lost;
    bit [3:0] mask;
  } ev_t;

  ev_t q[$];
  int  m_ts, m_drop;
  bit  m_ovf, m_pend;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=0x%08h exp=0x%08h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_dout(input int tsw);
    logic [31:0] v, t;
    if (q.size() == 0) return 32'd0;
    t = 32'(q[0].ts % (1 << tsw));
    v = (t << (32 - tsw)) | (32'(q[0].lost) << 4) | 32'(q[0].mask);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_drop = 0; m_ovf = 0; m_pend = 0;
  endtask

  task automatic check_all();
    check_eq("dout",       dout,        exp_dout(16));
    check_eq("dout_ts4",   dout4,       exp_dout(4));
    check_eq("empty",      32'(empty),  32'(q.size() == 0));
    check_eq("full",       32'(full),   32'(q.size() == 8));
    check_eq("count",      32'(count),  32'(q.size()));
    check_eq("count_ts4",  32'(count4), 32'(q.size()));
    check_eq("overflow",   32'(overflow),   32'(m_ovf));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // One clock cycle: drive inputs, advance the model by the rules, check after the edge.
  task automatic cyc(input logic [3:0] p, input logic [3:0] en, input logic r, input logic c);
    bit [3:0] ev;
    bit       isfull, wr, drop;
    pressed = p; btn_en = en; rd_en = r; clr_ovf = c;
    if (rst_n) begin
      ev     = p & en;
      isfull = (q.size() == 8);
      wr     = (ev != 0) && (!isfull || r);
      drop   = (ev != 0) && isfull && !r;
      if (drop) begin
        m_ovf  = 1;
        m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        m_pend = 1;
      end else if (c) begin
        m_ovf = 0; m_drop = 0;
      end
      if (r && q.size() > 0) void'(q.pop_front());
      if (wr) begin
        q.push_back('{ts: m_ts, lost: m_pend && !drop, mask: ev});
        m_pend = 0;
      end
      m_ts++;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(4'h0, 4'hF, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; pressed = '0; btn_en = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (3) cyc(4'hF, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single event at timestamp 5, then pop
    idle(5);
    cyc(4'b0010, 4'hF, 1'b0, 1'b0);
    check_eq("first_entry", dout, {16'd5, 11'd0, 1'b0, 4'b0010});
    cyc(4'h0, 4'hF, 1'b1, 1'b0);

    // Mask filter and merge
    cyc(4'b1111, 4'b0101, 1'b0, 1'b0);
    cyc(4'b1010, 4'b0101, 1'b0, 1'b0);
    check_eq("masked_count", 32'(count), 32'd1);
    drain();

    // Fill, three drops, pop, refill and lost-flag sequencing
    for (int i = 0; i < 8; i++) cyc(4'(i + 1), 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'h8, 4'hF, 1'b0, 1'b0);
    check_eq("drops3", 32'(drop_count), 32'd3);
    cyc(4'h0, 4'hF, 1'b1, 1'b0);
    cyc(4'h4, 4'hF, 1'b0, 1'b0);
    // Full with a simultaneous pop: no drop, count stays at eight
    cyc(4'h2, 4'hF, 1'b1, 1'b0);
    check_eq("full_rw_count", 32'(count), 32'd8);
    drain();
    cyc(4'h1, 4'hF, 1'b1, 1'b0);
    check_eq("empty_rw_count", 32'(count), 32'd1);
    drain();

    // Saturation, clear alone, clear with drop
    for (int i = 0; i < 8; i++) cyc(4'h1, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(4'h3, 4'hF, 1'b0, 1'b0);
    check_eq("drop_sat", 32'(drop_count), 32'd255);
    cyc(4'h0, 4'hF, 1'b0, 1'b1);
    cyc(4'h1, 4'hF, 1'b0, 1'b1);
    check_eq("clr_drop", 32'(drop_count), 32'd1);
    drain();

    // Timestamp wrap on the 4-bit twin: event at 15 followed by one at 0
    while ((m_ts % 16) != 15) idle(1);
    cyc(4'h1, 4'hF, 1'b0, 1'b0);
    cyc(4'h2, 4'hF, 1'b0, 1'b0);
    cyc(4'h0, 4'hF, 1'b1, 1'b0);
    check_eq("wrap_ts0", dout4[31:28], 32'd0);
    drain();

    // Random traffic with phases biased towards filling or draining
    for (int ph = 0; ph < 20; ph++) begin
      int rd_pct;
      rd_pct = (ph % 2 == 0) ? 15 : 80;
      for (int i = 0; i < 80; i++) begin
        logic [3:0] p, en;
        p  = ($urandom_range(0, 99) < 45) ? 4'($urandom_range(0, 15)) : 4'h0;
        en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        cyc(p, en, ($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 99) < 3));
      end
    end

    // Asynchronous reset in the middle of a write cycle
    for (int i = 0; i < 5; i++) cyc(4'h5, 4'hF, 1'b0, 1'b0);
    pressed = 4'h3; btn_en = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_dout", dout, 32'd0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);
    cyc(4'h8, 4'hF, 1'b0, 1'b0);
    check_eq("post_rst_ts", dout, {16'd2, 11'd0, 1'b0, 4'b1000});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
